conv2_filter_sched: RTL and testbench



---
 rtl/conv2_sched_pkg.sv | 20 ++
 rtl/conv2_win_counter.sv | 40 ++++
 rtl/conv2_filter_sched.sv | 119 +++++++++++
 tb/tb_conv2_filter_sched.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv2_sched_pkg.sv
// Shared types and helpers for the conv2 filter scheduler.
// Optional ReLU at result capture is enabled by defining CONV2_SCHED_RELU_EN.
package conv2_sched_pkg;

  localparam int unsigned DATA_W_DEF = 14;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } sched_state_e;

  function automatic int unsigned win_per_frame(input int unsigned map_w,
                                                input int unsigned map_h,
                                                input int unsigned filter_size);
    return (map_w - filter_size + 1) * (map_h - filter_size + 1);
  endfunction

endpackage

// File: rtl/conv2_win_counter.sv
// Counts completed windows, wraps at the end of a frame and pulses frame_done_o
// in the cycle after the final window completes.
module conv2_win_counter #(
  parameter int unsigned WIN_PER_FRAME = 64,
  parameter int unsigned CNT_W         = $clog2(WIN_PER_FRAME + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic win_done_i,
  output logic frame_done_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             frame_done_q, frame_done_d;
  logic             last_win;

  assign last_win = (cnt_q == CNT_W'(WIN_PER_FRAME - 1));

  always_comb begin
    cnt_d        = cnt_q;
    frame_done_d = 1'b0;
    if (win_done_i) begin
      cnt_d        = last_win ? '0 : cnt_q + CNT_W'(1);
      frame_done_d = last_win;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign frame_done_o = frame_done_q;

endmodule

// File: rtl/conv2_filter_sched.sv
// Shares one conv2 MAC datapath across NUM_FILT filters: one request per filter
// per window, results streamed out with valid/ready. ReLU option: CONV2_SCHED_RELU_EN.
module conv2_filter_sched
  import conv2_sched_pkg::*;
#(
  parameter  int unsigned NUM_FILT    = 3,
  parameter  int unsigned MAP_W       = 12,
  parameter  int unsigned MAP_H       = 12,
  parameter  int unsigned FILTER_SIZE = 5,
  parameter  int unsigned DATA_W      = DATA_W_DEF,
  localparam int unsigned FS_W        = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     win_valid,
  output logic                     win_ready,
  output logic                     calc_start,
  output logic [FS_W-1:0]          filt_sel,
  input  logic                     calc_valid,
  input  logic signed [DATA_W-1:0] calc_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] out_data,
  output logic [FS_W-1:0]          out_ch,
  output logic                     frame_done,
  output logic                     err_unexp
);

  localparam int unsigned WPF = win_per_frame(MAP_W, MAP_H, FILTER_SIZE);

  sched_state_e             state_q, state_d;
  logic [FS_W-1:0]          k_q, k_d;
  logic signed [DATA_W-1:0] out_data_q, out_data_d;
  logic [FS_W-1:0]          out_ch_q, out_ch_d;
  logic                     err_q, err_d;
  logic                     win_done;
  logic signed [DATA_W-1:0] cap_data;

  always_comb begin
`ifdef CONV2_SCHED_RELU_EN
    cap_data = calc_data[DATA_W-1] ? '0 : calc_data;
`else
    cap_data = calc_data;
`endif
  end

  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    out_data_d = out_data_q;
    out_ch_d   = out_ch_q;
    win_done   = 1'b0;
    // A result outside WAIT is dropped but remembered until reset.
    err_d      = err_q | (calc_valid & (state_q != WAIT));
    case (state_q)
      IDLE: begin
        if (win_valid) begin
          state_d = ISSUE;
          k_d     = '0;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (calc_valid) begin
          out_data_d = cap_data;
          out_ch_d   = k_q;
          state_d    = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          if (k_q == FS_W'(NUM_FILT - 1)) begin
            k_d      = '0;
            win_done = 1'b1;
            state_d  = IDLE;
          end else begin
            k_d     = k_q + FS_W'(1);
            state_d = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      k_q        <= '0;
      out_data_q <= '0;
      out_ch_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      out_data_q <= out_data_d;
      out_ch_q   <= out_ch_d;
      err_q      <= err_d;
    end
  end

  conv2_win_counter #(
    .WIN_PER_FRAME(WPF)
  ) u_win_counter (
    .clk         (clk),
    .rst_n       (rst_n),
    .win_done_i  (win_done),
    .frame_done_o(frame_done)
  );

  assign win_ready  = (state_q == IDLE);
  assign calc_start = (state_q == ISSUE);
  assign filt_sel   = k_q;
  assign out_valid  = (state_q == OUT);
  assign out_data   = out_data_q;
  assign out_ch     = out_ch_q;
  assign err_unexp  = err_q;

endmodule

// File: tb/tb_conv2_filter_sched.sv
// Directed bench for conv2_filter_sched with a 1-cycle-latency datapath model.
module tb_conv2_filter_sched;

  localparam int DW = 14;
`ifdef CONV2_SCHED_RELU_EN
  localparam int EXP_CH1 = 0;
`else
  localparam int EXP_CH1 = -5;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 win_valid;
  logic                 win_ready;
  logic                 calc_start;
  logic [1:0]           filt_sel;
  logic                 calc_valid = 1'b0;
  logic signed [DW-1:0] calc_data  = '0;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;
  logic [1:0]           out_ch;
  logic                 frame_done;
  logic                 err_unexp;

  always #5 clk = ~clk;

  conv2_filter_sched #(
    .NUM_FILT   (3),
    .MAP_W      (12),
    .MAP_H      (12),
    .FILTER_SIZE(5),
    .DATA_W     (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .win_valid (win_valid),
    .win_ready (win_ready),
    .calc_start(calc_start),
    .filt_sel  (filt_sel),
    .calc_valid(calc_valid),
    .calc_data (calc_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .frame_done(frame_done),
    .err_unexp (err_unexp)
  );

  // Datapath model: answers a calc_start with calc_valid in the following cycle.
  int   resp [3]  = '{10, -5, 7};
  int   exp_d [3] = '{10, EXP_CH1, 7};
  logic pend      = 1'b0;
  int   pend_data = 0;
  logic dp_en     = 1'b1;
  logic spur      = 1'b0;

  always @(negedge clk) begin
    calc_valid = pend | spur;
    calc_data  = DW'(pend_data);
    pend       = rst_n & calc_start & dp_en;
    pend_data  = resp[filt_sel];
  end

  int acc_cnt = 0;
  int fd_cnt  = 0;
  int fd_acc  = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) acc_cnt++;
      if (frame_done) begin
        fd_cnt++;
        fd_acc = acc_cnt;
      end
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send_window();
    win_valid = 1'b1;
    @(posedge clk); #1;
    win_valid = 1'b0;
    check("win_to_start", int'(calc_start), 1);
  endtask

  task automatic expect_filter(input int k, input int d);
    int n;
    n = 0;
    while (!calc_start && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("calc_start", int'(calc_start), 1);
    check("filt_sel", int'(filt_sel), k);
    @(posedge clk); #1;
    check("start_one_cycle", int'(calc_start), 0);
    n = 0;
    while (!out_valid && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    check("out_valid", int'(out_valid), 1);
    check("out_ch", int'(out_ch), k);
    check("out_data", int'(out_data), d);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base, fdb;
    rst_n     = 1'b0;
    win_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_win_ready", int'(win_ready), 1);
    check("rst_calc_start", int'(calc_start), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_ch", int'(out_ch), 0);
    check("rst_filt_sel", int'(filt_sel), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_err", int'(err_unexp), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single window, out_ready held high.
    send_window();
    check("busy_win_ready", int'(win_ready), 0);
    for (int k = 0; k < 3; k++) begin
      expect_filter(k, exp_d[k]);
      @(posedge clk); #1;
    end
    check("win_ready_back", int'(win_ready), 1);
    check("idle_out_valid", int'(out_valid), 0);

    // Backpressure on channel 1.
    send_window();
    expect_filter(0, exp_d[0]);
    @(posedge clk); #1;
    expect_filter(1, exp_d[1]);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", int'(out_valid), 1);
      check("bp_out_data", int'(out_data), exp_d[1]);
      check("bp_out_ch", int'(out_ch), 1);
      check("bp_no_start", int'(calc_start), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_start", int'(calc_start), 1);
    check("bp_release_sel", int'(filt_sel), 2);
    expect_filter(2, exp_d[2]);
    @(posedge clk); #1;
    check("bp_win_ready", int'(win_ready), 1);

    // Spurious calc_valid in IDLE.
    spur = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    check("spur_err", int'(err_unexp), 1);
    repeat (3) @(posedge clk);
    #1;
    check("spur_err_sticky", int'(err_unexp), 1);
    check("spur_idle", int'(win_ready), 1);
    check("spur_no_out", int'(out_valid), 0);

    // Reset while waiting on the datapath.
    dp_en = 1'b0;
    send_window();
    repeat (2) @(posedge clk);
    #1;
    check("wait_busy", int'(win_ready), 0);
    check("wait_no_out", int'(out_valid), 0);
    rst_n = 1'b0;
    spur  = 1'b1;
    @(posedge clk); #1;
    spur = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_idle", int'(win_ready), 1);
    check("mid_rst_err", int'(err_unexp), 0);
    check("mid_rst_sel", int'(filt_sel), 0);
    check("mid_rst_out", int'(out_valid), 0);
    rst_n = 1'b1;
    dp_en = 1'b1;
    @(posedge clk); #1;
    check("post_rst_err", int'(err_unexp), 0);
    send_window();
    for (int k = 0; k < 3; k++) begin
      expect_filter(k, exp_d[k]);
      @(posedge clk); #1;
    end
    check("post_rst_idle", int'(win_ready), 1);
    check("post_rst_err2", int'(err_unexp), 0);

    // Two full frames of 64 windows each.
    do_reset();
    for (int f = 0; f < 2; f++) begin
      base = acc_cnt;
      fdb  = fd_cnt;
      for (int w = 0; w < 64; w++) begin
        if (w == 63) check("fd_none_early", fd_cnt - fdb, 0);
        send_window();
        for (int k = 0; k < 3; k++) begin
          expect_filter(k, exp_d[k]);
          @(posedge clk); #1;
        end
      end
      check("frame_done_pulse", int'(frame_done), 1);
      @(posedge clk); #1;
      check("frame_done_clear", int'(frame_done), 0);
      check("frame_results", acc_cnt - base, 192);
      check("frame_done_count", fd_cnt - fdb, 1);
      check("frame_done_at", fd_acc - base, 192);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
